// File: rtl/shim_sts_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shim_sts_pkg : shared types and constants for the SPI status shim |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package shim_sts_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } sts_state_t;

    localparam logic [31:0] STS_STICKY_MASK_DEFAULT = 32'h0000_FFFF;
    localparam logic [31:0] STS_TIMEOUT_DEFAULT     = 32'd10_000_000;
    localparam int          STS_COUNT_W             = 16;

    // Saturating increment: an all-ones count stays put.
    function automatic logic [STS_COUNT_W-1:0] sts_count_inc(input logic [STS_COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_incoherent.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_incoherent : per-bit 2-FF synchronizer, no inter-bit coherence|
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module sync_incoherent #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shim_spi_sts_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shim_spi_sts_sync : toggle-handshake receiver for SPI status words |
// | Optional watchdog: SHIM_STS_WATCHDOG_EN.          Revision 1.0     |
// +------------------------------------------------------------------+
module shim_spi_sts_sync
    import shim_sts_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] STICKY_MASK = WIDTH'(STS_STICKY_MASK_DEFAULT),
    parameter logic [31:0]      TIMEOUT     = STS_TIMEOUT_DEFAULT
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   sts_req,
    input  logic [WIDTH-1:0]       sts_data,
    output logic                   sts_ack,
    input  logic                   sts_clr,
    output logic [WIDTH-1:0]       sts_word,
    output logic [WIDTH-1:0]       sts_sticky,
    output logic                   sts_update,
    output logic [STS_COUNT_W-1:0] sts_count,
    output logic                   sts_stale
);

    sts_state_t             state;
    logic                   req_sync;
    logic                   req_last;
    logic                   change;
    logic                   capture;
    logic [WIDTH-1:0]       sticky_nxt;
    logic [STS_COUNT_W-1:0] word_count;
    logic [STS_COUNT_W-1:0] count_nxt;

    sync_incoherent #(
        .WIDTH (1)
    ) u_req_sync (
        .clk    (aclk),
        .resetn (aresetn),
        .d      (sts_req),
        .q      (req_sync)
    );

    // req_last counts consumed events, so an edge arriving during ACK stays pending.
    assign change  = req_sync ^ req_last;
    assign capture = (state == ST_IDLE) && change;

    // Clear takes effect first, then the capture lands on top of it.
    always_comb begin
        sticky_nxt = sts_clr ? '0 : sts_sticky;
        count_nxt  = sts_clr ? '0 : word_count;
        if (capture) begin
            sticky_nxt = sticky_nxt | (sts_data & STICKY_MASK);
            count_nxt  = sts_count_inc(count_nxt);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            req_last   <= 1'b0;
            sts_ack    <= 1'b0;
            sts_word   <= '0;
            sts_update <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sts_update <= change;
                    if (change) begin
                        sts_word <= sts_data;
                        state    <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    sts_update <= 1'b0;
                    sts_ack    <= ~sts_ack;
                    req_last   <= ~req_last;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sts_sticky <= '0;
            word_count <= '0;
        end else begin
            sts_sticky <= sticky_nxt;
            word_count <= count_nxt;
        end
    end

    assign sts_count = word_count;

`ifdef SHIM_STS_WATCHDOG_EN
    logic [31:0] wd_cnt;
    logic        stale_r;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd_cnt  <= '0;
            stale_r <= 1'b0;
        end else if (capture || sts_clr) begin
            wd_cnt  <= '0;
            stale_r <= 1'b0;
        end else begin
            if (~&wd_cnt) begin
                wd_cnt <= wd_cnt + 32'd1;
            end
            stale_r <= (wd_cnt >= TIMEOUT);
        end
    end

    assign sts_stale = stale_r;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign sts_stale      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shim_spi_sts_sync.sv
`default_nettype none
// Directed + randomized bench for shim_spi_sts_sync against a word-level model.
module tb_shim_spi_sts_sync;

    localparam logic [31:0] MASK = 32'h0000_FFFF;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        sts_req;
    logic [31:0] sts_data;
    logic        sts_ack;
    logic        sts_clr;
    logic [31:0] sts_word;
    logic [31:0] sts_sticky;
    logic        sts_update;
    logic [15:0] sts_count;
    logic        sts_stale;

    always #5 aclk = ~aclk;

    shim_spi_sts_sync #(
        .WIDTH       (32),
        .STICKY_MASK (32'h0000_FFFF),
        .TIMEOUT     (32'd100)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .sts_req    (sts_req),
        .sts_data   (sts_data),
        .sts_ack    (sts_ack),
        .sts_clr    (sts_clr),
        .sts_word   (sts_word),
        .sts_sticky (sts_sticky),
        .sts_update (sts_update),
        .sts_count  (sts_count),
        .sts_stale  (sts_stale)
    );

    // Word-level reference state
    logic [31:0] m_word;
    logic [31:0] m_sticky;
    int          m_count;
    logic        m_ack;

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_word   = '0;
        m_sticky = '0;
        m_count  = 0;
        m_ack    = 1'b0;
    endtask

    task automatic model_capture(input logic [31:0] w, input bit clr);
        if (clr) begin
            m_sticky = '0;
            m_count  = 0;
        end
        m_sticky = m_sticky | (w & MASK);
        m_count  = (m_count >= 65535) ? 65535 : m_count + 1;
        m_word   = w;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".word"},   sts_word,          m_word);
        check({tag, ".sticky"}, sts_sticky,        m_sticky);
        check({tag, ".count"},  32'(sts_count),    32'(m_count));
    endtask

    // Flip the request just after edge 0; capture lands on edge 3, ack on edge 4.
    task automatic send(input string tag, input logic [31:0] w, input bit clr_on_cap);
        @(posedge aclk);
        #1;
        sts_data = w;
        sts_req  = ~sts_req;
        repeat (2) @(posedge aclk);
        #1;
        check({tag, ".upd_early"}, 32'(sts_update), 32'd0);
        sts_clr = clr_on_cap;
        @(posedge aclk);
        #1;
        sts_clr = 1'b0;
        model_capture(w, clr_on_cap);
        @(negedge aclk);
        check({tag, ".upd_hi"}, 32'(sts_update), 32'd1);
        check({tag, ".ack_hold"}, 32'(sts_ack), 32'(m_ack));
        check_state(tag);
        @(negedge aclk);
        m_ack = ~m_ack;
        check({tag, ".upd_lo"}, 32'(sts_update), 32'd0);
        check({tag, ".ack"},    32'(sts_ack),    32'(m_ack));
        repeat (2) @(posedge aclk);
    endtask

    task automatic clear_only(input string tag);
        @(posedge aclk);
        #1 sts_clr = 1'b1;
        @(posedge aclk);
        #1 sts_clr = 1'b0;
        m_sticky = '0;
        m_count  = 0;
        @(negedge aclk);
        check_state(tag);
    endtask

    initial begin
        int upd_seen;
        aresetn  = 1'b0;
        sts_req  = 1'b0;
        sts_data = '0;
        sts_clr  = 1'b0;
        model_reset();
        repeat (3) @(negedge aclk);
        check("rst.ack",    32'(sts_ack),    32'd0);
        check("rst.update", 32'(sts_update), 32'd0);
        check("rst.stale",  32'(sts_stale),  32'd0);
        check_state("rst");
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);

        send("w5", 32'h0000_0005, 1'b0);
        send("w10002", 32'h0001_0002, 1'b0);
        send("w8", 32'h0000_0008, 1'b0);
        check("mask.sticky", sts_sticky, 32'h0000_000F);
        send("clrcap", 32'h0000_0010, 1'b1);
        clear_only("clr");

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) clear_only("rnd.clr");
            send("rnd", $urandom, ($urandom_range(0, 3) == 0));
        end

        @(negedge aclk);
        dut.word_count = 16'hFFFE;
        m_count = 16'hFFFE;
        for (int i = 0; i < 3; i++) send("sat", $urandom, 1'b0);
        check("sat.count", 32'(sts_count), 32'h0000_FFFF);

        // Reset with the request held high: exactly one capture afterwards.
        if (sts_req == 1'b0) send("pre_rst", $urandom, 1'b0);
        @(negedge aclk);
        sts_data = $urandom;
        aresetn  = 1'b0;
        model_reset();
        #1;
        check("mid_rst.ack", 32'(sts_ack), 32'd0);
        check_state("mid_rst");
        repeat (2) @(negedge aclk);
        aresetn  = 1'b1;
        upd_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk);
            if (sts_update) upd_seen++;
        end
        model_capture(sts_data, 1'b0);
        check("post_rst.updates", 32'(upd_seen), 32'd1);
        check("post_rst.ack",     32'(sts_ack),  32'd1);
        check_state("post_rst");
        m_ack = 1'b1;

        repeat (120) @(posedge aclk);
        @(negedge aclk);
`ifdef SHIM_STS_WATCHDOG_EN
        check("stale.idle", 32'(sts_stale), 32'd1);
        send("stale.cap", 32'h0000_0021, 1'b0);
        check("stale.after", 32'(sts_stale), 32'd0);
`else
        check("stale.off", 32'(sts_stale), 32'd0);
        send("stale.cap", 32'h0000_0021, 1'b0);
        check("stale.off2", 32'(sts_stale), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
